// File: rtl/gate_test_pkg.sv
// Shared definitions for the registered 2-input gate self-test: operation codes,
// checker FSM states and the golden gate function.
package gate_test_pkg;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_NAND = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Computed at the widest supported operand width; callers truncate to W.
    function automatic logic [3:0] golden(input logic [1:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [3:0] y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a & b);
        endcase
        return y;
    endfunction

endpackage

// File: rtl/exp_delay_line.sv
// LAT-deep {valid,data} shift register carrying expected results alongside the gate's own
// pipeline; synchronous clear drops any pending entries.
module exp_delay_line #(
    parameter int unsigned W   = 2,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid [LAT];
    logic [W-1:0] r_data  [LAT];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                r_valid[i] <= 1'b0;
                r_data[i]  <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int unsigned i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[LAT-1];
    assign o_data  = r_data[LAT-1];

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep initiator/checker for a registered 2-input gate: drives every operand
// pair, compares the returned result LAT cycles later and reports pass/mismatches.
module gate_sweep_checker
    import gate_test_pkg::*;
#(
    parameter int unsigned W   = 2,
    parameter int unsigned LAT = 1,
    parameter int unsigned OP  = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [W-1:0]   a_o,
    output logic [W-1:0]   b_o,
    input  logic [W-1:0]   y_i,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   err_cnt,
    output logic [W-1:0]   fail_a,
    output logic [W-1:0]   fail_b
);

    localparam int unsigned IW = 2 * W;
    localparam int unsigned CW = 2 * W + 1;
    localparam int unsigned DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

    state_e        r_state;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_cmp_idx;
    logic [DW-1:0] r_drain;
    logic [CW-1:0] r_err;
    logic [W-1:0]  r_fail_a;
    logic [W-1:0]  r_fail_b;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;

    logic          w_start_ok;
    logic [W-1:0]  w_gold;
    logic          w_cmp_valid;
    logic [W-1:0]  w_cmp_exp;
    logic          w_mismatch;
    logic [CW-1:0] w_err_next;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_gold     = W'(golden(2'(OP), 4'(r_idx[IW-1:W]), 4'(r_idx[W-1:0])));

    exp_delay_line #(
        .W   (W),
        .LAT (LAT)
    ) u_exp_delay_line (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start_ok),
        .i_valid (r_state == DRIVE),
        .i_data  (w_gold),
        .o_valid (w_cmp_valid),
        .o_data  (w_cmp_exp)
    );

    assign w_mismatch = w_cmp_valid && (y_i != w_cmp_exp);
    assign w_err_next = (w_mismatch && (r_err != '1)) ? r_err + 1'b1 : r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_cmp_idx <= '0;
            r_drain   <= '0;
            r_err     <= '0;
            r_fail_a  <= '0;
            r_fail_b  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_state   <= DRIVE;
                r_idx     <= '0;
                r_cmp_idx <= '0;
                r_err     <= '0;
                r_fail_a  <= '0;
                r_fail_b  <= '0;
                r_pass    <= 1'b0;
                r_busy    <= 1'b1;
            end else begin
                r_err <= w_err_next;
                // r_cmp_idx tracks which vector the delay-line output belongs to.
                if (w_mismatch && (r_err == '0)) begin
                    r_fail_a <= r_cmp_idx[IW-1:W];
                    r_fail_b <= r_cmp_idx[W-1:0];
                end
                if (w_cmp_valid) begin
                    r_cmp_idx <= r_cmp_idx + 1'b1;
                end
                case (r_state)
                    DRIVE: begin
                        if (r_idx == '1) begin
                            r_state <= DRAIN;
                            r_drain <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (r_drain == DRAIN_LAST) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_drain <= r_drain + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign a_o     = r_idx[IW-1:W];
    assign b_o     = r_idx[W-1:0];
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err;
    assign fail_a  = r_fail_a;
    assign fail_b  = r_fail_b;

endmodule
